// File: rtl/viterbi_traceback_if.sv
// Stream interface for the Viterbi traceback unit.
//   in_*      : decision-vector stream from the ACS/CS array (valid/ready)
//   out_*     : decoded-bit stream to the sink (valid/ready)
//   overflow  : sticky frame-truncation flag
// master = producer/sink side (testbench or neighbouring blocks),
// slave  = the traceback block itself.
interface viterbi_traceback_if #(
  parameter int NSTATES = 4
);
  logic               in_valid;
  logic               in_ready;
  logic [NSTATES-1:0] in_dec;
  logic               in_last;
  logic               out_valid;
  logic               out_ready;
  logic               out_bit;
  logic               out_last;
  logic               overflow;

  modport master (
    output in_valid, in_dec, in_last, out_ready,
    input  in_ready, out_valid, out_bit, out_last, overflow
  );

  modport slave (
    input  in_valid, in_dec, in_last, out_ready,
    output in_ready, out_valid, out_bit, out_last, overflow
  );
endinterface

// File: rtl/viterbi_traceback.sv
// Viterbi survivor memory + traceback.
// Collects one decision vector per trellis step (FILL), traces back from
// START_STATE over the stored frame one step per cycle (TRACE), then replays
// the decoded bits in forward order on a valid/ready stream (EMIT).
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset, aborts any frame in flight
//   bus  : viterbi_traceback_if.slave (decision stream in, bit stream out,
//          sticky overflow)
module viterbi_traceback #(
  parameter int K           = 3,
  parameter int MAX_LEN     = 64,
  parameter int START_STATE = 0
) (
  input  logic                clk,
  input  logic                rst,
  viterbi_traceback_if.slave  bus
);
  localparam int              NSTATES   = 1 << (K-1);
  localparam int              AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [AW-1:0]   ONE       = AW'(1);
  localparam logic [AW-1:0]   LAST_SLOT = AW'(MAX_LEN-1);
  localparam logic [K-2:0]    START     = (K-1)'(START_STATE);

  typedef enum logic [1:0] {FILL, TRACE, EMIT} state_e;

  state_e             state_q;
  logic [NSTATES-1:0] mem_q [MAX_LEN];
  logic [MAX_LEN-1:0] bits_q;
  logic [AW-1:0]      cnt_q, last_q, ptr_q, idx_q;
  logic [K-2:0]       st_q;
  logic               in_ready_q, out_valid_q, out_bit_q, out_last_q, overflow_q;

  logic               accept;
  logic               dec_bit;
  logic [K-2:0]       st_pred;
  logic [AW-1:0]      idx_nxt;

  // in_ready_q is high exactly while in FILL, so it doubles as the state gate.
  assign accept  = in_ready_q && bus.in_valid;
  // Combinational survivor read keeps TRACE at one step per cycle.
  assign dec_bit = mem_q[ptr_q][st_q];
  // Predecessor: shift the state left, bring in the stored decision bit.
  assign st_pred = {st_q[K-3:0], dec_bit};
  assign idx_nxt = idx_q + ONE;

  always_ff @(posedge clk) begin
    if (accept) mem_q[cnt_q] <= bus.in_dec;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FILL;
      cnt_q       <= '0;
      last_q      <= '0;
      ptr_q       <= '0;
      idx_q       <= '0;
      st_q        <= START;
      bits_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_bit_q   <= 1'b0;
      out_last_q  <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      case (state_q)
        FILL: begin
          if (accept) begin
            cnt_q <= cnt_q + ONE;
            // Frame ends on in_last or when this write fills the memory.
            if (bus.in_last || cnt_q == LAST_SLOT) begin
              last_q     <= cnt_q;
              ptr_q      <= cnt_q;
              st_q       <= START;
              in_ready_q <= 1'b0;
              state_q    <= TRACE;
              if (!bus.in_last) overflow_q <= 1'b1;
            end
          end
        end
        TRACE: begin
          bits_q[ptr_q] <= st_q[K-2];
          st_q          <= st_pred;
          ptr_q         <= ptr_q - ONE;
          if (ptr_q == '0) begin
            // bits[0] is being produced this cycle; forward it straight out.
            state_q     <= EMIT;
            idx_q       <= '0;
            out_valid_q <= 1'b1;
            out_bit_q   <= st_q[K-2];
            out_last_q  <= (last_q == '0);
          end
        end
        EMIT: begin
          if (bus.out_ready) begin
            if (out_last_q) begin
              state_q     <= FILL;
              cnt_q       <= '0;
              in_ready_q  <= 1'b1;
              out_valid_q <= 1'b0;
              out_bit_q   <= 1'b0;
              out_last_q  <= 1'b0;
            end else begin
              idx_q      <= idx_nxt;
              out_bit_q  <= bits_q[idx_nxt];
              out_last_q <= (idx_nxt == last_q);
            end
          end
        end
        default: state_q <= FILL;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_bit   = out_bit_q;
  assign bus.out_last  = out_last_q;
  assign bus.overflow  = overflow_q;
endmodule

// File: doc/viterbi_traceback.md
Name: viterbi_traceback

Overview:
- Reader side of the ACS/CS decision stream: consumes one decision vector per trellis step, one bit per state, as produced by the compare-select array.
- Stores a full frame of decision vectors in survivor memory.
- After the frame ends, traces back from the known terminating state and replays the decoded bits in forward order over a valid/ready stream.
- Sits between the ACS array and the decoded-bit sink at the back of the Viterbi decoder.

Parameters:
K, 3, constraint length; K >= 3.
NSTATES, 2**(K-1), trellis state count and decision vector width.
MAX_LEN, 64, maximum trellis steps per frame (survivor memory depth).
START_STATE, 0, state traceback begins from (terminated trellis).

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
in_valid  in  1  decision vector valid
in_ready  out  1  block accepts decision vectors
in_dec  in  NSTATES  decision bits; in_dec[s] = dec bit of state s's surviving branch
in_last  in  1  this vector is the final trellis step of the frame
out_valid  out  1  decoded bit valid
out_ready  in  1  sink accepts decoded bit
out_bit  out  1  decoded bit
out_last  out  1  final decoded bit of frame
overflow  out  1  sticky: frame truncated at MAX_LEN

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values:
  - State FILL.
  - Step count 0.
  - in_ready=1, out_valid=0, out_bit=0, out_last=0, overflow=0.
  - Memory contents undefined.
- Reset mid-operation: reset in any state aborts the frame; no partial output follows.
- Trellis convention: next_state = {u, state[K-2:1]}.
  - Traceback from state s at step t: decoded u = s[K-2]; d = dec[t][s]; predecessor = {s[K-3:0], d}.
- FILL:
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready: write in_dec to mem[cnt], cnt++.
  - If in_last, or cnt==MAX_LEN-1 (the step being written fills memory): N=cnt+1, go to TRACE.
  - The MAX_LEN case without in_last also sets overflow.
- TRACE:
  - in_ready=0, out_valid=0.
  - ptr starts at N-1; trace state starts at START_STATE.
  - Each cycle: bits[ptr]=st[K-2]; st={st[K-3:0], mem[ptr][st]}; ptr--.
  - After processing ptr==0, go to EMIT with idx=0.
  - Occupies exactly N cycles.
- EMIT:
  - out_valid=1; out_bit=bits[idx]; out_last=(idx==N-1).
  - On out_valid&&out_ready: idx++.
  - On the handshake with out_last: go to FILL, cnt=0, out_valid=0 next cycle.
  - out_bit and out_last hold stable while out_valid&&!out_ready.
- Latency: last vector accepted at edge e0. TRACE covers cycles e0+1..e0+N. out_valid first high in cycle e0+N+1.
- Single-step frame (in_last on first vector, N=1) is legal: one TRACE cycle, one output bit with out_last=1.
- in_dec/in_last are ignored when in_valid=0 or when not in FILL.
- overflow is cleared only by rst.
- The block performs no metric arithmetic. Memory is MAX_LEN x NSTATES bits with a combinational or registered read; a registered read adds pipeline stages internally but must preserve the cycle counts above.

Test Plan:
- K=3, frame of 6 vectors in_dec = 4'b1011, 4'b1101, 4'b0100, 4'b0111, 4'b0010, 4'b0001, in_last on the 6th -> out_bit stream 1,0,1,1,0,0; out_last only on 6th bit; first out_valid 7 cycles after last accept; overflow=0.
- Same frame with out_ready toggling 1,0,0,1,... -> identical bit sequence. out_bit/out_last hold while stalled. in_ready stays 0 until after the final handshake.
- Single vector 4'b0000 with in_last -> exactly one output bit 0 with out_last=1; block returns to FILL with in_ready=1.
- MAX_LEN=8, 8 vectors of all zeros, no in_last -> overflow=1 after 8th accept. 8 output bits all 0, out_last on 8th. in_ready=0 during TRACE/EMIT.
- Assert rst for one cycle during EMIT after 3 bits emitted -> next cycle out_valid=0, in_ready=1, overflow=0. A fresh 6-vector frame then decodes 1,0,1,1,0,0 correctly.
- Back-to-back frames: second frame's in_valid held high throughout -> first vector of frame 2 accepted in the cycle after frame 1's last output handshake; both frames decode correctly.
